// File: rtl/tinyalu_core.sv
// TinyALU core: start/done handshake around add/and/xor (one cycle) and a pipelined mul.
// Optional macro TINYALU_ILLEGAL_OP_EN adds an illegal_op pulse for opcodes 101..111.
module tinyalu_core #(
  parameter int MUL_LATENCY = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  input  logic [2:0]  op,
  input  logic        start,
`ifdef TINYALU_ILLEGAL_OP_EN
  output logic        illegal_op,
`endif
  output logic        done,
  output logic [15:0] result
);

  typedef enum logic [1:0] {
    IDLE,
    SINGLE,
    MUL,
    REARM
  } state_t;

  state_t      state;
  logic [7:0]  a_q;
  logic [7:0]  b_q;
  logic [2:0]  op_q;
  logic        issue;

  logic [MUL_LATENCY-2:0] pipe_valid;
  logic [15:0]            pipe_prod [MUL_LATENCY-1];

  // Stage 0 multiplies the captured operands; later stages only delay the product so
  // the last stage is valid one cycle before done must rise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pipe_valid <= '0;
      for (int k = 0; k < MUL_LATENCY - 1; k++) pipe_prod[k] <= 16'h0000;
    end else begin
      pipe_valid[0] <= issue;
      pipe_prod[0]  <= {8'h00, a_q} * {8'h00, b_q};
      for (int k = 1; k < MUL_LATENCY - 1; k++) begin
        pipe_valid[k] <= pipe_valid[k-1];
        pipe_prod[k]  <= pipe_prod[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      done   <= 1'b0;
      result <= 16'h0000;
      a_q    <= 8'h00;
      b_q    <= 8'h00;
      op_q   <= 3'b000;
      issue  <= 1'b0;
`ifdef TINYALU_ILLEGAL_OP_EN
      illegal_op <= 1'b0;
`endif
    end else begin
      done  <= 1'b0;
      issue <= 1'b0;
`ifdef TINYALU_ILLEGAL_OP_EN
      illegal_op <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (start) begin
            case (op)
              3'b001, 3'b010, 3'b011: begin
                a_q   <= A;
                b_q   <= B;
                op_q  <= op;
                state <= SINGLE;
              end
              3'b100: begin
                a_q   <= A;
                b_q   <= B;
                op_q  <= op;
                issue <= 1'b1;
                state <= MUL;
              end
              default: begin
`ifdef TINYALU_ILLEGAL_OP_EN
                if (op[2]) begin
                  illegal_op <= 1'b1;
                  state      <= REARM;
                end
`endif
              end
            endcase
          end
        end
        SINGLE: begin
          done  <= 1'b1;
          state <= REARM;
          case (op_q)
            3'b001:  result <= {8'h00, a_q} + {8'h00, b_q};
            3'b010:  result <= {8'h00, a_q & b_q};
            default: result <= {8'h00, a_q ^ b_q};
          endcase
        end
        MUL: begin
          if (pipe_valid[MUL_LATENCY-2]) begin
            done   <= 1'b1;
            result <= pipe_prod[MUL_LATENCY-2];
            state  <= REARM;
          end
        end
        REARM: begin
          // A start still held after done must not launch another operation.
          if (!start) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tinyalu_core.sv
// Scoreboard bench for tinyalu_core: the driver queues expected results and done cycles,
// a negedge monitor pops and compares on every done pulse.
module tb_tinyalu_core;

  localparam int LAT = 3;

  logic        clk;
  logic        reset_n;
  logic [7:0]  A;
  logic [7:0]  B;
  logic [2:0]  op;
  logic        start;
  logic        done;
  logic [15:0] result;
`ifdef TINYALU_ILLEGAL_OP_EN
  logic        illegal_op;
  int          ill_cnt = 0;
`endif

  typedef struct {
    logic [15:0] res;
    int          at;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;

  tinyalu_core #(.MUL_LATENCY(LAT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .A       (A),
    .B       (B),
    .op      (op),
    .start   (start),
`ifdef TINYALU_ILLEGAL_OP_EN
    .illegal_op (illegal_op),
`endif
    .done    (done),
    .result  (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every done must match the oldest queued expectation, in value and cycle.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n && done) begin
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_done at cycle %0d: got done=1 result=%h, required no done", cyc, result);
      end else begin
        e = sb.pop_front();
        compared++;
        if (result !== e.res) begin
          mismatched++;
          $display("[TB] FAIL done_result: got %h, required %h", result, e.res);
        end
        compared++;
        if (cyc !== e.at) begin
          mismatched++;
          $display("[TB] FAIL done_cycle: got %0d, required %0d", cyc, e.at);
        end
      end
    end
`ifdef TINYALU_ILLEGAL_OP_EN
    if (reset_n && illegal_op) ill_cnt++;
`endif
  end

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
    end
  endtask

  // Issue one operation, hold start for lat+hold cycles, then drop it for a cycle.
  task automatic applyStimulus(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                               input logic [15:0] exp_res, input int lat, input int hold);
    @(negedge clk);
    op = o;
    A = a;
    B = b;
    start = 1'b1;
    sb.push_back('{exp_res, cyc + 1 + lat});
    repeat (lat + hold) @(negedge clk);
    start = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0;
    start = 1'b0;
    op = 3'b000;
    A = 8'h00;
    B = 8'h00;
    repeat (2) @(negedge clk);
    checkOutput("reset_done", {15'h0, done}, 16'h0000);
    checkOutput("reset_result", result, 16'h0000);
    reset_n = 1'b1;
    @(negedge clk);

    // add with start held 5 more cycles after done
    applyStimulus(3'b001, 8'hFF, 8'hFF, 16'h01FE, 1, 6);
    applyStimulus(3'b100, 8'hFF, 8'hFF, 16'hFE01, LAT, 1);
    applyStimulus(3'b100, 8'h0C, 8'h0A, 16'h0078, LAT, 1);
    applyStimulus(3'b010, 8'hF0, 8'h3C, 16'h0030, 1, 1);
    repeat (3) @(negedge clk);
    checkOutput("and_result_held", result, 16'h0030);
    applyStimulus(3'b011, 8'hF0, 8'h3C, 16'h00CC, 1, 1);

    // no_op and unused opcode: no done, result unchanged
    @(negedge clk);
    op = 3'b000;
    A = 8'h55;
    B = 8'h66;
    start = 1'b1;
    repeat (4) @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checkOutput("noop_result", result, 16'h00CC);
    op = 3'b101;
    start = 1'b1;
    repeat (4) @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checkOutput("op101_result", result, 16'h00CC);
`ifdef TINYALU_ILLEGAL_OP_EN
    checkOutput("illegal_pulses", 16'(ill_cnt), 16'h0001);
`endif

    // inputs changed during MUL are ignored; the add runs only after start re-rises
    @(negedge clk);
    op = 3'b100;
    A = 8'h10;
    B = 8'h10;
    start = 1'b1;
    sb.push_back('{16'h0100, cyc + 1 + LAT});
    @(negedge clk);
    op = 3'b001;
    A = 8'h01;
    B = 8'h01;
    repeat (LAT) @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checkOutput("mul_ignores_inputs", result, 16'h0100);
    applyStimulus(3'b001, 8'h01, 8'h01, 16'h0002, 1, 1);

    // asynchronous reset one cycle after a mul capture
    @(negedge clk);
    op = 3'b100;
    A = 8'h10;
    B = 8'h10;
    start = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    checkOutput("async_reset_done", {15'h0, done}, 16'h0000);
    checkOutput("async_reset_result", result, 16'h0000);
    start = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("post_reset_result", result, 16'h0000);

    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL missing_done: got %0d outstanding, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
